// File: rtl/topk_merge_unit.sv
// Purpose: top-K (data, index) merge engine. PASS re-emits a candidate set, MERGE
//          sorted-merges candidates A with the kept set B (truncated to K), COLLECT
//          gathers LANES scalars from lane 0 and emits them as one beat.
// Latency: last input beat to first o_out_valid is 1 cycle (PASS) or K+1 cycles (MERGE).
// Backpressure: valid/ready both sides; a stalled output beat is held stable, and
//               o_in_ready is low outside the load/collect states.
// Optional feature: define TOPK_DESC_EN to honour i_desc (descending merge);
//                   otherwise the merge is always ascending and i_desc is ignored.
// Ports: clk, rst (async, active-low); i_start/i_op/i_desc command;
//        i_in_valid/o_in_ready/i_in_data input beats;
//        o_out_valid/i_out_ready/o_out_data/o_out_last output beats;
//        o_busy (not IDLE), o_done (one-cycle completion pulse).
// Set layout over NB = ceil(2K/LANES) beats: K data words, K index words, zero pad.
module topk_merge_unit #(
   parameter int K     = 20,
   parameter int LANES = 16,
   parameter int DW    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [1:0]            i_op,
   input  logic                  i_desc,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [LANES*DW-1:0]   i_in_data,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic [LANES*DW-1:0]   o_out_data,
   output logic                  o_out_last,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int NB = (2 * K + LANES - 1) / LANES;
   localparam int KW = (K > 1) ? $clog2(K) : 1;

   localparam logic [9:0] NB_LAST = 10'(NB - 1);
   localparam logic [9:0] K_C     = 10'(K);
   localparam logic [9:0] K_LAST  = 10'(K - 1);
   localparam logic [9:0] L_LAST  = 10'(LANES - 1);

   localparam logic [1:0] OP_PASS    = 2'b01;
   localparam logic [1:0] OP_COLLECT = 2'b11;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD_A  = 3'd1;
   localparam logic [2:0] S_LOAD_B  = 3'd2;
   localparam logic [2:0] S_MERGE   = 3'd3;
   localparam logic [2:0] S_EMIT    = 3'd4;
   localparam logic [2:0] S_COLLECT = 3'd5;

   logic [2:0]    r_state;
   logic          r_pass;     // PASS loads straight into R, skipping B and the merge
   logic          r_col;      // EMIT is presenting the collected scalar beat
   logic          r_done;
   logic [9:0]    r_cnt;      // beat / scalar counter
   logic [9:0]    r_i, r_j, r_k;

   logic [DW-1:0] r_a_dat [K];
   logic [DW-1:0] r_a_idx [K];
   logic [DW-1:0] r_b_dat [K];
   logic [DW-1:0] r_b_idx [K];
   logic [DW-1:0] r_r_dat [K];
   logic [DW-1:0] r_r_idx [K];
   logic [DW-1:0] r_c     [LANES];

   logic          w_in_fire, w_out_fire, w_take_a, w_cmp;
   logic [KW-1:0] w_ai, w_bj;
   logic [DW-1:0] w_a, w_b;
   logic [LANES*DW-1:0] w_out;

   assign o_in_ready  = (r_state == S_LOAD_A) || (r_state == S_LOAD_B) || (r_state == S_COLLECT);
   assign o_out_valid = (r_state == S_EMIT);
   assign o_out_last  = (r_state == S_EMIT) && (r_col || (r_cnt == NB_LAST));
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = r_done;
   assign o_out_data  = w_out;

   assign w_in_fire  = i_in_valid && o_in_ready;
   assign w_out_fire = o_out_valid && i_out_ready;

   // Exhausted pointers are parked at 0; w_take_a never selects them.
   assign w_ai = (r_i < K_C) ? r_i[KW-1:0] : '0;
   assign w_bj = (r_j < K_C) ? r_j[KW-1:0] : '0;
   assign w_a  = r_a_dat[w_ai];
   assign w_b  = r_b_dat[w_bj];

`ifdef TOPK_DESC_EN
   logic r_desc;
   assign w_cmp = r_desc ? (w_a > w_b) : (w_a < w_b);
`else
   logic w_desc_unused;
   assign w_desc_unused = i_desc;
   assign w_cmp = (w_a < w_b);
`endif

   // Strict compare: ties fall to B.
   assign w_take_a = (r_i < K_C) && ((r_j >= K_C) || w_cmp);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_pass  <= 1'b0;
         r_col   <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_k     <= '0;
`ifdef TOPK_DESC_EN
         r_desc  <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start && (i_op != 2'b00)) begin
                  r_pass  <= (i_op == OP_PASS);
                  r_col   <= 1'b0;
                  r_cnt   <= '0;
                  r_i     <= '0;
                  r_j     <= '0;
                  r_k     <= '0;
`ifdef TOPK_DESC_EN
                  r_desc  <= i_desc;
`endif
                  r_state <= (i_op == OP_COLLECT) ? S_COLLECT : S_LOAD_A;
               end
            end
            S_LOAD_A: begin
               if (w_in_fire) begin
                  if (r_cnt == NB_LAST) begin
                     r_cnt   <= '0;
                     r_state <= r_pass ? S_EMIT : S_LOAD_B;
                  end else begin
                     r_cnt <= r_cnt + 10'd1;
                  end
               end
            end
            S_LOAD_B: begin
               if (w_in_fire) begin
                  if (r_cnt == NB_LAST) begin
                     r_cnt   <= '0;
                     r_state <= S_MERGE;
                  end else begin
                     r_cnt <= r_cnt + 10'd1;
                  end
               end
            end
            S_MERGE: begin
               if (w_take_a) r_i <= r_i + 10'd1;
               else          r_j <= r_j + 10'd1;
               r_k <= r_k + 10'd1;
               if (r_k == K_LAST) r_state <= S_EMIT;
            end
            S_EMIT: begin
               if (w_out_fire) begin
                  if (o_out_last) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                     r_cnt   <= '0;
                     r_col   <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 10'd1;
                  end
               end
            end
            S_COLLECT: begin
               if (w_in_fire) begin
                  if (r_cnt == L_LAST) begin
                     r_cnt   <= '0;
                     r_col   <= 1'b1;
                     r_state <= S_EMIT;
                  end else begin
                     r_cnt <= r_cnt + 10'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Storage arrays carry no reset; their contents only matter after a full load.
   // Set word p lives in beat p/LANES, lane p%LANES; pad words are never stored.
   always_ff @(posedge clk) begin
      if (w_in_fire && (r_state == S_LOAD_A)) begin
         for (int k = 0; k < K; k++) begin
            if (r_cnt == 10'(k / LANES)) begin
               if (r_pass) r_r_dat[k] <= i_in_data[(k % LANES)*DW +: DW];
               else        r_a_dat[k] <= i_in_data[(k % LANES)*DW +: DW];
            end
            if (r_cnt == 10'((K + k) / LANES)) begin
               if (r_pass) r_r_idx[k] <= i_in_data[((K + k) % LANES)*DW +: DW];
               else        r_a_idx[k] <= i_in_data[((K + k) % LANES)*DW +: DW];
            end
         end
      end
      if (w_in_fire && (r_state == S_LOAD_B)) begin
         for (int k = 0; k < K; k++) begin
            if (r_cnt == 10'(k / LANES))
               r_b_dat[k] <= i_in_data[(k % LANES)*DW +: DW];
            if (r_cnt == 10'((K + k) / LANES))
               r_b_idx[k] <= i_in_data[((K + k) % LANES)*DW +: DW];
         end
      end
      if (w_in_fire && (r_state == S_COLLECT)) begin
         for (int w = 0; w < LANES; w++)
            if (r_cnt == 10'(w)) r_c[w] <= i_in_data[DW-1:0];
      end
      if (r_state == S_MERGE) begin
         r_r_dat[r_k[KW-1:0]] <= w_take_a ? w_a : w_b;
         r_r_idx[r_k[KW-1:0]] <= w_take_a ? r_a_idx[w_ai] : r_b_idx[w_bj];
      end
   end

   // Output beat is a pure function of state, counter and R, so it holds while stalled.
   always_comb begin
      w_out = '0;
      if (r_state == S_EMIT) begin
         if (r_col) begin
            for (int w = 0; w < LANES; w++) w_out[w*DW +: DW] = r_c[w];
         end else begin
            for (int k = 0; k < K; k++) begin
               if (r_cnt == 10'(k / LANES))
                  w_out[(k % LANES)*DW +: DW] = r_r_dat[k];
               if (r_cnt == 10'((K + k) / LANES))
                  w_out[((K + k) % LANES)*DW +: DW] = r_r_idx[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_topk_merge_unit.sv
// Purpose: directed self-checking bench for topk_merge_unit (K=4, LANES=4, DW=32, NB=2).
// Latency: checks PASS (1 cycle) and MERGE (K+1 cycles) first-output timing.
// Backpressure: holds out_ready low in EMIT and checks the beat stays stable.
module tb_topk_merge_unit;
   localparam int K = 4;
   localparam int LANES = 4;
   localparam int DW = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic         desc;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         out_last;
   logic         busy;
   logic         done;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   topk_merge_unit #(.K(K), .LANES(LANES), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .i_start(start), .i_op(op), .i_desc(desc),
      .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .o_out_last(out_last), .o_busy(busy), .o_done(done)
   );

   function automatic logic [127:0] pk(input logic [31:0] w0, w1, w2, w3);
      return {w3, w2, w1, w0};
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic go(input logic [1:0] o, input logic d);
      start = 1'b1; op = o; desc = d;
      @(posedge clk); #1;
      start = 1'b0; op = 2'b00; desc = 1'b0;
   endtask

   task automatic send(input logic [127:0] d);
      int cyc;
      cyc = 0;
      in_valid = 1'b1; in_data = d;
      while (!in_ready && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      if (!in_ready) chk("send_timeout", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = '0;
   endtask

   task automatic recv(input string tag, input logic [127:0] d, input logic last);
      int cyc;
      cyc = 0;
      out_ready = 1'b1;
      while (!out_valid && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_vld"}, 128'(out_valid), 128'd1);
      chk({tag, "_dat"}, out_data, d);
      chk({tag, "_last"}, 128'(out_last), 128'(last));
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic done_chk(input string tag);
      chk({tag, "_done"}, 128'(done), 128'd1);
      chk({tag, "_idle"}, 128'(busy), 128'd0);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 128'(done), 128'd0);
   endtask

   task automatic merge_lat(input string tag);
      int cyc;
      cyc = 0;
      chk({tag, "_no_in_ready"}, 128'(in_ready), 128'd0);
      while (!out_valid && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_latency"}, 128'(cyc), 128'(K));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; start = 1'b0; op = 2'b00; desc = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_in_ready",  128'(in_ready),  128'd0);
      chk("rst_busy",      128'(busy),      128'd0);
      chk("rst_done",      128'(done),      128'd0);
      chk("rst_out_last",  128'(out_last),  128'd0);
      chk("rst_out_data",  out_data,        128'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Reserved op is ignored.
      go(2'b00, 1'b0);
      chk("op00_ignored", 128'(busy), 128'd0);

      // PASS
      go(2'b01, 1'b0);
      chk("pass_busy", 128'(busy), 128'd1);
      send(pk(5, 7, 9, 11));
      send(pk(0, 1, 2, 3));
      chk("pass_latency", 128'(out_valid), 128'd1);
      recv("pass_b0", pk(5, 7, 9, 11), 1'b0);
      recv("pass_b1", pk(0, 1, 2, 3), 1'b1);
      done_chk("pass");

      // MERGE ascending with a tie
      go(2'b10, 1'b0);
      send(pk(1, 4, 6, 8));
      send(pk(10, 11, 12, 13));
      send(pk(2, 4, 5, 9));
      send(pk(20, 21, 22, 23));
      merge_lat("masc");
      recv("masc_b0", pk(1, 2, 4, 4), 1'b0);
      recv("masc_b1", pk(10, 20, 21, 11), 1'b1);
      done_chk("masc");

      // MERGE with desc=1
      go(2'b10, 1'b1);
      send(pk(9, 7, 3, 1));
      send(pk(30, 31, 32, 33));
      send(pk(8, 7, 2, 0));
      send(pk(40, 41, 42, 43));
      merge_lat("mdesc");
`ifdef TOPK_DESC_EN
      recv("mdesc_b0", pk(9, 8, 7, 7), 1'b0);
      recv("mdesc_b1", pk(30, 40, 41, 31), 1'b1);
`else
      recv("mdesc_b0", pk(8, 7, 2, 0), 1'b0);
      recv("mdesc_b1", pk(40, 41, 42, 43), 1'b1);
`endif
      done_chk("mdesc");

      // COLLECT with start pulses while busy
      go(2'b11, 1'b0);
      send(pk(3, 99, 98, 97));
      go(2'b01, 1'b0);
      send(pk(1, 55, 56, 57));
      go(2'b10, 1'b0);
      send(pk(4, 66, 67, 68));
      send(pk(1, 77, 78, 79));
      recv("col", pk(3, 1, 4, 1), 1'b1);
      done_chk("col");
      chk("col_start_ignored", 128'(busy), 128'd0);

      // Output stall: beat held, stray input ignored
      go(2'b01, 1'b0);
      send(pk(21, 22, 23, 24));
      send(pk(25, 26, 27, 28));
      in_valid = 1'b1; in_data = pk(1000, 1001, 1002, 1003);
      for (int i = 0; i < 5; i++) begin
         chk("hold_vld", 128'(out_valid), 128'd1);
         chk("hold_dat", out_data, pk(21, 22, 23, 24));
         chk("hold_last", 128'(out_last), 128'd0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_data = '0;
      recv("hold_b0", pk(21, 22, 23, 24), 1'b0);
      recv("hold_b1", pk(25, 26, 27, 28), 1'b1);
      done_chk("hold");

      // Reset during MERGE
      go(2'b10, 1'b0);
      send(pk(1, 4, 6, 8));
      send(pk(10, 11, 12, 13));
      send(pk(2, 4, 5, 9));
      send(pk(20, 21, 22, 23));
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("mrst_busy",      128'(busy),      128'd0);
      chk("mrst_out_valid", 128'(out_valid), 128'd0);
      chk("mrst_out_data",  out_data,        128'd0);
      chk("mrst_in_ready",  128'(in_ready),  128'd0);
      chk("mrst_done",      128'(done),      128'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         chk("mrst_no_output", 128'(out_valid), 128'd0);
         @(posedge clk); #1;
      end
      go(2'b01, 1'b0);
      send(pk(100, 200, 300, 400));
      send(pk(1, 2, 3, 4));
      chk("post_rst_latency", 128'(out_valid), 128'd1);
      recv("post_rst_b0", pk(100, 200, 300, 400), 1'b0);
      recv("post_rst_b1", pk(1, 2, 3, 4), 1'b1);
      done_chk("post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/topk_merge_unit.md
TOPK_MERGE_UNIT -- requirements
Module: topk_merge_unit

Interface
REQ-001 Parameter K, default 20, number of kept (data, index) pairs; legal range 1 to 256.
REQ-002 Parameter LANES, default 16, words per beat; legal range 2 to 32.
REQ-003 Parameter DW, default 32, bits per data and index word.
REQ-004 Derived NB = ceil(2K/LANES) is the beats per set; a set is K data words, then K index words, then zero pad.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle command strobe, sampled only in IDLE.
REQ-008 op  input  2  command: 01 PASS, 10 MERGE, 11 COLLECT, 00 reserved (ignored).
REQ-009 desc  input  1  sort order, latched with start: 0 ascending, 1 descending.
REQ-010 in_valid / in_ready  input / output  1 / 1  input beat handshake.
REQ-011 in_data  input  LANES*DW  input beat; word w is at bits [w*DW +: DW].
REQ-012 out_valid / out_ready  output / input  1 / 1  output beat handshake.
REQ-013 out_data  output  LANES*DW  output beat, with the same lane packing as in_data.
REQ-014 out_last  output  1  marks the final beat of a result.
REQ-015 busy / done  output / output  1 / 1  busy is high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, MERGE, EMIT and COLLECT.
REQ-017 IDLE transitions on start with a legal op: PASS or MERGE goes to LOAD_A; COLLECT goes to COLLECT. The start is ignored when busy=1 or op=00.
REQ-018 A beat SHALL transfer only in a cycle with in_valid && in_ready; in_ready=1 only in LOAD_A, LOAD_B and COLLECT.
REQ-019 LOAD_A SHALL capture NB candidate beats into the A arrays (data and index) and discard pad words.
REQ-020 After LOAD_A: PASS goes to EMIT with R=A; MERGE goes to LOAD_B.
REQ-021 LOAD_B SHALL capture NB beats of the previously kept set into the B arrays, then go to MERGE.
REQ-022 MERGE SHALL produce exactly one result pair per cycle over K cycles, as a two-pointer merge of A and B truncated to K entries.
REQ-023 In ascending mode the merge takes A[i] only if A[i] < B[j]; in descending mode it takes A[i] only if A[i] > B[j]. Ties SHALL take B, and each index word travels with its data word.
REQ-024 The merge comparison SHALL be unsigned, at DW bits.
REQ-025 When one pointer reaches K, the merge SHALL fill the remaining slots from the other array.
REQ-026 EMIT SHALL present NB beats of R, packed per REQ-004 with pad words zero; out_last=1 on beat NB-1.
REQ-027 out_data and out_last SHALL be held stable while out_valid && !out_ready.
REQ-028 After the last output handshake: done=1 for one cycle, then IDLE. Latency from the last input beat to the first out_valid is 1 cycle for PASS and K+1 cycles for MERGE.
REQ-029 COLLECT SHALL take lane 0 of LANES accepted beats in order and then emit one beat, word w being the w-th scalar, with out_last=1.
REQ-030 Inputs presented while in_ready=0 SHALL have no effect.

Reset
REQ-031 While rst=0: FSM=IDLE, all counters and pointers are 0, and out_valid, out_last, in_ready, busy, done and out_data are all 0.
REQ-032 Reset mid-operation SHALL abort the operation; partial results are never emitted; the A, B and R contents are don't-care after reset.

Configuration
REQ-033 Macro TOPK_DESC_EN defined: desc is honoured per REQ-023.
REQ-034 Macro TOPK_DESC_EN undefined: desc is ignored, the compare is always ascending, and the descending comparator logic is absent.

Verification (K=4, LANES=4, DW=32, NB=2)
REQ-035 PASS with beats {5,7,9,11},{0,1,2,3} -> two output beats identical to the input; out_last on beat 2; done one cycle after it.
REQ-036 MERGE, asc, A=data{1,4,6,8} idx{10,11,12,13}, B=data{2,4,5,9} idx{20,21,22,23} -> data{1,2,4,4}, idx{10,20,21,11}.
REQ-037 MERGE, desc (TOPK_DESC_EN defined), A={9,7,3,1}, B={8,7,2,0} -> data{9,8,7,7}, with B winning the 7 tie. With the macro undefined the same stimulus merges ascending.
REQ-038 COLLECT of scalars 3,1,4,1 -> one beat {3,1,4,1}, out_last=1; start pulses while busy are ignored.
REQ-039 Hold out_ready=0 for 5 cycles in EMIT -> out_data stable; then resume and complete normally.
REQ-040 Assert rst=0 during MERGE -> all outputs 0 immediately; a following PASS completes correctly.
